// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core: reset defaults, opcodes and
// instruction field widths used by fetch, decode and sign_extend.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JADDR_W  = 26;

    localparam logic [DATA_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [DATA_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/pc_register.sv
// Program counter with redirect-over-stall priority and the sequential +4 adder.
module pc_register
    import mips_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_target,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    // Redirect wins even under stall so a resolved branch is never lost;
    // targets are word-aligned by clearing the low two bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target & ~32'h0000_0003;
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch PC plus IF/ID pipeline register, with the registered
// instruction split into decode fields.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [DATA_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [DATA_W-1:0]   redirect_target,
    output logic [DATA_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_rdata,
    output logic [DATA_W-1:0]   id_instr,
    output logic [DATA_W-1:0]   id_pc_plus4,
    output logic                id_valid,
    output logic [OPCODE_W-1:0] id_opcode,
    output logic [REG_W-1:0]    id_rs,
    output logic [REG_W-1:0]    id_rt,
    output logic [REG_W-1:0]    id_rd,
    output logic [SHAMT_W-1:0]  id_shamt,
    output logic [FUNCT_W-1:0]  id_funct,
    output logic [IMM_W-1:0]    id_imm16,
    output logic [JADDR_W-1:0]  id_jaddr,
    output logic [DATA_W-1:0]   fetch_count
);

    logic [DATA_W-1:0] pc_p0;
    logic [DATA_W-1:0] pc_plus4_p0;
    logic [DATA_W-1:0] instr_p1;
    logic [DATA_W-1:0] pc_plus4_p1;
    logic              vld_p1;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc              (pc_p0),
        .pc_plus4        (pc_plus4_p0)
    );

    assign imem_addr = pc_p0;

    // IF -> ID boundary: flush overrides stall; only real loads are counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1    <= NOP_WORD;
            pc_plus4_p1 <= '0;
            vld_p1      <= 1'b0;
            fetch_count <= '0;
        end else if (flush) begin
            instr_p1    <= NOP_WORD;
            pc_plus4_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (!stall) begin
            instr_p1    <= imem_rdata;
            pc_plus4_p1 <= pc_plus4_p0;
            vld_p1      <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign id_instr    = instr_p1;
    assign id_pc_plus4 = pc_plus4_p1;
    assign id_valid    = vld_p1;
    assign id_opcode   = instr_p1[31:26];
    assign id_rs       = instr_p1[25:21];
    assign id_rt       = instr_p1[20:16];
    assign id_rd       = instr_p1[15:11];
    assign id_shamt    = instr_p1[10:6];
    assign id_funct    = instr_p1[5:0];
    assign id_imm16    = instr_p1[15:0];
    assign id_jaddr    = instr_p1[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios with literal
// expectations plus randomized control traffic against a behavioural model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] id_instr, id_pc_plus4, fetch_count;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm16;
    logic [25:0] id_jaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16),
        .id_jaddr(id_jaddr), .fetch_count(fetch_count)
    );

    // Behavioural model: the architectural state after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_vld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0;
            m_vld <= 1'b0; m_cnt <= 32'h0;
        end else begin
            if (redirect)     m_pc <= (redirect_target / 4) * 4;
            else if (!stall)  m_pc <= m_pc + 4;
            if (flush) begin
                m_instr <= 32'h0; m_pc4 <= 32'h0; m_vld <= 1'b0;
            end else if (!stall) begin
                m_instr <= imem_rdata; m_pc4 <= m_pc + 4; m_vld <= 1'b1;
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m_addr",   imem_addr,   m_pc);
        check("m_instr",  id_instr,    m_instr);
        check("m_pc4",    id_pc_plus4, m_pc4);
        check("m_valid",  {31'b0, id_valid}, {31'b0, m_vld});
        check("m_count",  fetch_count, m_cnt);
        check("m_opcode", {26'b0, id_opcode}, (m_instr >> 26) & 32'h3F);
        check("m_rs",     {27'b0, id_rs},     (m_instr >> 21) & 32'h1F);
        check("m_rt",     {27'b0, id_rt},     (m_instr >> 16) & 32'h1F);
        check("m_rd",     {27'b0, id_rd},     (m_instr >> 11) & 32'h1F);
        check("m_shamt",  {27'b0, id_shamt},  (m_instr >> 6) & 32'h1F);
        check("m_funct",  {26'b0, id_funct},  m_instr & 32'h3F);
        check("m_imm16",  {16'b0, id_imm16},  m_instr & 32'hFFFF);
        check("m_jaddr",  {6'b0, id_jaddr},   m_instr & 32'h03FF_FFFF);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s; flush = f; redirect = r; redirect_target = t;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0);
        imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_count", fetch_count, 32'h0);

        // First fetch from RESET_PC.
        imem_rdata = 32'h2008_0005;
        rst_n = 1'b1;
        cyc();
        check("f1_instr", id_instr, 32'h2008_0005);
        check("f1_valid", {31'b0, id_valid}, 32'h1);
        check("f1_pc4",   id_pc_plus4, 32'h4);
        check("f1_imm",   {16'b0, id_imm16}, 32'h5);
        check("f1_addr",  imem_addr, 32'h4);
        check("f1_count", fetch_count, 32'h1);

        // Stall three cycles with changing fetch data.
        drive(1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            imem_rdata = $urandom;
            cyc();
            check("st_addr",  imem_addr, 32'h4);
            check("st_instr", id_instr, 32'h2008_0005);
            check("st_count", fetch_count, 32'h1);
        end
        drive(0, 0, 0, 32'h0);
        imem_rdata = 32'h0109_5020;
        cyc();
        check("rel_instr", id_instr, 32'h0109_5020);
        check("rel_pc4",   id_pc_plus4, 32'h8);
        check("rel_addr",  imem_addr, 32'h8);
        check("rel_count", fetch_count, 32'h2);

        // Redirect under stall: PC moves, IF/ID holds.
        drive(1, 0, 1, 32'h0000_0043);
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        check("rs_addr",  imem_addr, 32'h40);
        check("rs_instr", id_instr, 32'h0109_5020);
        check("rs_count", fetch_count, 32'h2);

        // Flush overrides stall.
        drive(1, 1, 0, 32'h0);
        cyc();
        check("fl_instr", id_instr, 32'h0);
        check("fl_valid", {31'b0, id_valid}, 32'h0);
        check("fl_op",    {26'b0, id_opcode}, 32'h0);
        check("fl_count", fetch_count, 32'h2);
        check("fl_addr",  imem_addr, 32'h40);

        // Redirect to the top word; delay slot from 0x40 still enters IF/ID.
        drive(0, 0, 1, 32'hFFFF_FFFC);
        imem_rdata = 32'h8C22_0010;
        cyc();
        check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        check("wr_slot",  id_pc_plus4, 32'h44);
        drive(0, 0, 0, 32'h0);
        imem_rdata = 32'h0800_0001;
        cyc();
        check("wr_addr1", imem_addr, 32'h0);
        check("wr_pc4",   id_pc_plus4, 32'h0);
        check("wr_op",    {26'b0, id_opcode}, 32'h2);
        cyc();
        check("wr_addr2", imem_addr, 32'h4);

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), $urandom);
            imem_rdata = $urandom;
            cyc();
        end

        // Asynchronous reset mid-cycle while stalled.
        drive(1, 0, 0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_instr", id_instr, 32'h0);
        check("ar_pc4",   id_pc_plus4, 32'h0);
        check("ar_valid", {31'b0, id_valid}, 32'h0);
        check("ar_count", fetch_count, 32'h0);
        check("ar_op",    {26'b0, id_opcode}, 32'h0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch program counter and IF/ID pipeline register for the 5-stage MIPS core.
- Drives the instruction-memory address. Captures the fetched word and PC+4, then splits the registered instruction into decode fields.
- The imm16 field feeds sign_extend directly. rs/rt feed the register file.
- Supports stall (hazard unit), flush, and redirect (branch/jump resolution).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted on flush or reset (sll $0,$0,0).

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC and IF/ID contents.
- flush  input  1  replace the next IF/ID contents with a bubble.
- redirect  input  1  load PC from redirect_target.
- redirect_target  input  32  branch/jump target byte address.
- imem_addr  output  32  current PC, to instruction memory (combinational read).
- imem_rdata  input  32  instruction at imem_addr, same cycle.
- id_instr  output  32  registered instruction.
- id_pc_plus4  output  32  registered PC+4 of id_instr.
- id_valid  output  1  id_instr is a real fetched instruction (not a bubble).
- id_opcode  output  6  id_instr[31:26].
- id_rs  output  5  id_instr[25:21].
- id_rt  output  5  id_instr[20:16].
- id_rd  output  5  id_instr[15:11].
- id_shamt  output  5  id_instr[10:6].
- id_funct  output  6  id_instr[5:0].
- id_imm16  output  16  id_instr[15:0], consumed by sign_extend.
- id_jaddr  output  26  id_instr[25:0].
- fetch_count  output  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (async on rst_n low, released synchronously by the next edge logic):
  - pc = RESET_PC
  - id_instr = NOP_WORD
  - id_pc_plus4 = 0
  - id_valid = 0
  - fetch_count = 0
  - All field outputs therefore read 0.
- imem_addr = pc, combinationally. There is one cycle of latency from PC to id_instr.
- PC update per edge, in priority order:
  - redirect=1: pc <= {redirect_target[31:2], 2'b00}. This applies even when stall=1; low address bits are always forced to zero.
  - stall=1: pc holds.
  - Otherwise: pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- IF/ID update per edge, in priority order:
  - flush=1: id_instr <= NOP_WORD, id_valid <= 0, id_pc_plus4 <= 0. Flush overrides stall.
  - stall=1: all IF/ID registers hold.
  - Otherwise: id_instr <= imem_rdata, id_pc_plus4 <= pc + 4, id_valid <= 1.
- fetch_count increments by 1, with wrap, only on edges where IF/ID loads a real instruction (no flush, no stall).
- Field outputs are pure combinational slices of id_instr. No extra latency.
- Redirect without flush: the instruction fetched in the redirect cycle still enters IF/ID (the delay slot). The hazard unit asserts flush when the slot must be squashed.
- Reset mid-operation: immediate return to reset values. Any in-flight fetch is discarded.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC and NOP_WORD defaults
  - opcode constants (OP_RTYPE 6'h00, OP_J 6'h02, OP_JAL 6'h03, OP_BEQ 6'h04, OP_BNE 6'h05, OP_ADDI 6'h08, OP_LW 6'h23, OP_SW 6'h2B)
  - field-width constants used by decode and sign_extend
- One sub-module: pc_register. It holds the PC with redirect/stall priority and the +4 adder. if_id_stage instantiates it and owns the IF/ID register and counter.

Test Plan:
- Reset, then release with imem returning 32'h2008_0005 at addr 0:
  - after edge 1: id_instr=32'h2008_0005, id_valid=1, id_pc_plus4=4, id_imm16=16'h0005, imem_addr=4, fetch_count=1.
- stall=1 for 3 cycles with imem_rdata changing: pc and id_instr frozen, fetch_count unchanged. On release, sequential fetching resumes from the held pc.
- redirect=1, target 32'h0000_0043, with stall=1 in the same cycle: next imem_addr=32'h0000_0040. IF/ID holds.
- flush=1 and stall=1 together: id_instr=0, id_valid=0, id_opcode=0, fetch_count unchanged.
- redirect=1 to 32'hFFFF_FFFC, then two free-running cycles: imem_addr sequence FFFF_FFFC → 0000_0000. id_pc_plus4 for the FFFF_FFFC fetch = 0.
- Assert rst_n low mid-cycle while stalled: outputs return to reset values without waiting for a clock edge.
